pipelined_prefix_adder: RTL and testbench

//  Parametrised, pipelined Kogge-Stone parallel-prefix adder/subtractor: the next generation of the 16-bit combinational prefix adder.

---
 rtl/prefix_adder_pkg.sv | 24 ++
 rtl/prefix_level.sv | 23 ++
 rtl/pipelined_prefix_adder.sv | 171 +++++++++++++++++
 tb/tb_pipelined_prefix_adder.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prefix_adder_pkg.sv
// Shared types and helpers for the pipelined Kogge-Stone adder.
//   pg_t        : generate/propagate pair for one bit or one prefix group
//   pg_combine  : prefix operator, merging a higher group with the adjacent lower group
//   num_stages  : pipeline stages needed to cover clog2(width) prefix levels
package prefix_adder_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } pg_t;

    // hi covers the more significant bits and lo the bits directly below them.
    function automatic pg_t pg_combine(input pg_t hi, input pg_t lo);
        pg_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

    function automatic int num_stages(input int width, input int lvl_per_stg);
        return ($clog2(width) + lvl_per_stg - 1) / lvl_per_stg;
    endfunction

endpackage

// File: rtl/prefix_level.sv
// One combinational Kogge-Stone level. Each bit combines with the bit SPAN
// positions below it. Bits with no partner in range pass through unchanged.
//   pg_in  : group g/p per bit entering this level
//   pg_out : group g/p per bit leaving this level
module prefix_level
    import prefix_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SPAN  = 1
) (
    input  pg_t [WIDTH-1:0] pg_in,
    output pg_t [WIDTH-1:0] pg_out
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i < SPAN) begin : g_pass
            assign pg_out[i] = pg_in[i];
        end else begin : g_comb
            assign pg_out[i] = pg_combine(pg_in[i], pg_in[i-SPAN]);
        end
    end

endmodule

// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone adder/subtractor with a valid/ready handshake.
// Stage 0 registers the bitwise g/p terms. Each later stage registers the
// result of LVL_PER_STG prefix levels. The final stage registers sum and flags.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake
//   in_a, in_b           : operands
//   in_cin               : carry-in, used in add mode only
//   in_sub               : 1 selects A - B, 0 selects A + B + cin
//   in_tag               : sideband value returned with the result
//   out_valid / out_ready: result handshake
//   out_sum              : sum or difference, modulo 2^WIDTH
//   out_cout             : carry out of the MSB (for subtraction, 1 = no borrow)
//   out_ovf              : signed overflow
//   out_zero             : out_sum == 0
//   out_tag              : tag of this result
module pipelined_prefix_adder
    import prefix_adder_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int LVL_PER_STG = 2,
    parameter int TAG_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int LOG2W = $clog2(WIDTH);
    localparam int NSTG  = num_stages(WIDTH, LVL_PER_STG);

    // vld[NSTG] is the output register's valid bit. vld[0..NSTG-1] belong to
    // the internal stages.
    logic [NSTG:0]    vld;
    logic [NSTG:0]    rdy;
    logic             rst_done;
    logic             accept;

    pg_t  [WIDTH-1:0] pg_r  [NSTG];
    logic [WIDTH-1:0] x_r   [NSTG];
    logic             c0_r  [NSTG];
    logic [TAG_W-1:0] tag_r [NSTG];

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] x_in;
    logic             c0_in;
    pg_t  [WIDTH-1:0] pg_in;

    // NOTE: every always_comb output is assigned first, so no path holds an
    // old value and no latch is inferred.
    always_comb begin
        b_eff = in_sub ? ~in_b : in_b;
        c0_in = in_sub | in_cin;
        x_in  = in_a ^ b_eff;
        for (int i = 0; i < WIDTH; i++) begin
            pg_in[i].g = in_a[i] & b_eff[i];
            pg_in[i].p = in_a[i] | b_eff[i];
        end
        // Fold the carry-in into bit 0. The prefix g terms then become the
        // true carry out of each bit.
        pg_in[0].g = pg_in[0].g | (pg_in[0].p & c0_in);
    end

    // A stage can accept data when it or any stage after it has room. This
    // OR-reduction is the unrolled form of rdy[k] = !vld[k] || rdy[k+1].
    for (genvar s = 0; s <= NSTG; s++) begin : g_rdy
        assign rdy[s] = out_ready || !(&vld[NSTG:s]);
    end

    assign in_ready  = rst_done && rdy[0];
    assign accept    = in_valid && in_ready;
    assign out_valid = vld[NSTG];

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld      <= '0;
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
            if (rdy[0]) vld[0] <= accept;
            for (int s = 1; s <= NSTG; s++) begin
                if (rdy[s]) vld[s] <= vld[s-1];
            end
        end
    end

    // Prefix levels. The first level of each stage reads that stage's input
    // register. The other levels chain combinationally.
    pg_t [WIDTH-1:0] lvl_in  [LOG2W];
    pg_t [WIDTH-1:0] lvl_out [LOG2W];

    for (genvar k = 0; k < LOG2W; k++) begin : g_lvl
        if (k % LVL_PER_STG == 0) begin : g_head
            assign lvl_in[k] = pg_r[k / LVL_PER_STG];
        end else begin : g_chain
            assign lvl_in[k] = lvl_out[k-1];
        end
        prefix_level #(.WIDTH(WIDTH), .SPAN(1 << k)) u_level (
            .pg_in  (lvl_in[k]),
            .pg_out (lvl_out[k])
        );
    end

    pg_t [WIDTH-1:0] stg_pg [NSTG];
    assign stg_pg[0] = pg_in;
    for (genvar s = 1; s < NSTG; s++) begin : g_stg_in
        assign stg_pg[s] = lvl_out[s*LVL_PER_STG-1];
    end

    // NOTE: the internal datapath registers have no reset. Their valid bits
    // already mark them as empty, and leaving the reset off keeps the
    // enable-only flops small.
    always_ff @(posedge clk) begin
        if (accept) begin
            pg_r[0]  <= stg_pg[0];
            x_r[0]   <= x_in;
            c0_r[0]  <= c0_in;
            tag_r[0] <= in_tag;
        end
        for (int s = 1; s < NSTG; s++) begin
            if (rdy[s] && vld[s-1]) begin
                pg_r[s]  <= stg_pg[s];
                x_r[s]   <= x_r[s-1];
                c0_r[s]  <= c0_r[s-1];
                tag_r[s] <= tag_r[s-1];
            end
        end
    end

    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] unused_p;
    logic [WIDTH-1:0] sum_nxt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_carry
        assign carry[i]    = lvl_out[LOG2W-1][i].g;
        assign unused_p[i] = lvl_out[LOG2W-1][i].p;
    end

    assign sum_nxt = x_r[NSTG-1] ^ {carry[WIDTH-2:0], c0_r[NSTG-1]};

    // The output registers are reset so the outputs read 0 until the first result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sum  <= '0;
            out_cout <= 1'b0;
            out_ovf  <= 1'b0;
            out_zero <= 1'b0;
            out_tag  <= '0;
        end else if (rdy[NSTG] && vld[NSTG-1]) begin
            out_sum  <= sum_nxt;
            out_cout <= carry[WIDTH-1];
            out_ovf  <= carry[WIDTH-1] ^ carry[WIDTH-2];
            out_zero <= ~|sum_nxt;
            out_tag  <= tag_r[NSTG-1];
        end
    end

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Directed bench for pipelined_prefix_adder. It uses a 16-bit / 2-level
// instance for most tests, plus a 13-bit / 1-level instance and a
// 64-bit / 3-level instance for the parameter corners.
module tb_pipelined_prefix_adder;

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic [3:0]  tag;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // Main instance: WIDTH=16, LVL_PER_STG=2, latency 3.
    logic        in_valid, in_ready, in_cin, in_sub;
    logic [15:0] in_a, in_b, out_sum;
    logic [3:0]  in_tag, out_tag;
    logic        out_valid, out_ready, out_cout, out_ovf, out_zero;

    pipelined_prefix_adder #(.WIDTH(16), .LVL_PER_STG(2), .TAG_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
        .out_zero(out_zero), .out_tag(out_tag)
    );

    // WIDTH=13, LVL_PER_STG=1, latency 5.
    logic        v13, r13, cin13, sub13, ov13, co13, of13, z13;
    logic [12:0] a13, b13, s13;
    logic [3:0]  t13, ot13;

    pipelined_prefix_adder #(.WIDTH(13), .LVL_PER_STG(1), .TAG_W(4)) u_dut13 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v13), .in_ready(r13),
        .in_a(a13), .in_b(b13), .in_cin(cin13), .in_sub(sub13), .in_tag(t13),
        .out_valid(ov13), .out_ready(1'b1),
        .out_sum(s13), .out_cout(co13), .out_ovf(of13),
        .out_zero(z13), .out_tag(ot13)
    );

    // WIDTH=64, LVL_PER_STG=3, latency 3.
    logic        v64, r64, cin64, sub64, ov64, co64, of64, z64;
    logic [63:0] a64, b64, s64;
    logic [3:0]  t64, ot64;

    pipelined_prefix_adder #(.WIDTH(64), .LVL_PER_STG(3), .TAG_W(4)) u_dut64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v64), .in_ready(r64),
        .in_a(a64), .in_b(b64), .in_cin(cin64), .in_sub(sub64), .in_tag(t64),
        .out_valid(ov64), .out_ready(1'b1),
        .out_sum(s64), .out_cout(co64), .out_ovf(of64),
        .out_zero(z64), .out_tag(ot64)
    );

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   stall_lo = 0;
    int   stall_hi = 0;
    int   pops = 0;
    logic accepted = 1'b0;
    logic saw_block = 1'b0;
    logic hold_vld = 1'b0;
    res_t hold_snap;
    res_t sb[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: widen, add, then read carry and overflow from the sign bits.
    function automatic res_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic cin, input logic sub, input logic [3:0] tag);
        logic [63:0] mask, am, bm;
        logic [64:0] full;
        res_t        r;
        mask   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        am     = a & mask;
        bm     = (sub ? ~b : b) & mask;
        full   = {1'b0, am} + {1'b0, bm} + {64'd0, (sub | cin)};
        r.sum  = full[63:0] & mask;
        r.cout = full[w];
        r.ovf  = (am[w-1] == bm[w-1]) && (full[w-1] != am[w-1]);
        r.zero = (r.sum == 64'd0);
        r.tag  = tag;
        return r;
    endfunction

    function automatic res_t obs_main();
        return {48'd0, out_sum, out_cout, out_ovf, out_zero, out_tag};
    endfunction

    // One clock of scoreboarded traffic on the main instance. It is entered
    // one time unit after a rising edge and returns at the same point of the
    // next cycle.
    task automatic cycle();
        out_ready = !(cyc >= stall_lo && cyc < stall_hi);
        #1;
        accepted = in_valid && in_ready;
        if (in_valid && !in_ready) saw_block = 1'b1;
        if (hold_vld) check("held_output", obs_main(), hold_snap);
        hold_vld  = out_valid && !out_ready;
        hold_snap = obs_main();
        if (out_valid && out_ready) begin
            if (sb.size() == 0) check("unexpected_result", out_valid, 1'b0);
            else                check("result", obs_main(), sb.pop_front());
            pops++;
        end
        if (accepted) sb.push_back(model(16, {48'd0, in_a}, {48'd0, in_b}, in_cin, in_sub, in_tag));
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string name, input logic [15:0] a, input logic [15:0] b,
                            input logic cin, input logic sub, input logic [15:0] esum,
                            input logic ecout, input logic eovf, input logic ezero);
        int lat;
        out_ready = 1'b1;
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_tag = 4'hA;
        in_valid = 1'b1;
        #1;
        check({name, "_in_ready"}, in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, "_latency"}, lat, 3);
        check({name, "_sum"}, out_sum, esum);
        check({name, "_cout"}, out_cout, ecout);
        check({name, "_ovf"}, out_ovf, eovf);
        check({name, "_zero"}, out_zero, ezero);
        check({name, "_tag"}, out_tag, 4'hA);
        @(posedge clk);
        #1;
    endtask

    // Single operation on a parameter-corner instance. w selects 13 or 64.
    task automatic param_op(input int w, input logic [63:0] a, input logic [63:0] b,
                            input logic cin, input logic sub, input logic [3:0] tag,
                            input int exp_lat);
        res_t exp_r, obs_r;
        int   lat;
        exp_r = model(w, a, b, cin, sub, tag);
        if (w == 13) begin
            a13 = a[12:0]; b13 = b[12:0]; cin13 = cin; sub13 = sub; t13 = tag; v13 = 1'b1;
        end else begin
            a64 = a; b64 = b; cin64 = cin; sub64 = sub; t64 = tag; v64 = 1'b1;
        end
        #1;
        check("param_in_ready", (w == 13) ? r13 : r64, 1'b1);
        @(posedge clk);
        #1;
        v13 = 1'b0;
        v64 = 1'b0;
        lat = 1;
        while (!((w == 13) ? ov13 : ov64) && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check((w == 13) ? "w13_latency" : "w64_latency", lat, exp_lat);
        if (w == 13) obs_r = {51'd0, s13, co13, of13, z13, ot13};
        else         obs_r = {s64, co64, of64, z64, ot64};
        check((w == 13) ? "w13_result" : "w64_result", obs_r, exp_r);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int tries;
        int nstall;

        rst_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; in_tag = '0;
        out_ready = 1'b1;
        v13 = 1'b0; a13 = '0; b13 = '0; cin13 = 1'b0; sub13 = 1'b0; t13 = '0;
        v64 = 1'b0; a64 = '0; b64 = '0; cin64 = 1'b0; sub64 = 1'b0; t64 = '0;

        // Outputs must read 0 while reset is held.
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_outputs", obs_main(), '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_rst", in_ready, 1'b1);

        // Add and subtract corners.
        directed("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        directed("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        directed("add_cin",   16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0);
        directed("sub_neg",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        directed("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        directed("sub_equal", 16'hABCD, 16'hABCD, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        directed("sub_cin_x", 16'h0003, 16'h0001, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);

        // Reset with three operations in flight. No stale result may appear afterwards.
        sb.delete(); hold_vld = 1'b0; stall_lo = 0; stall_hi = 0;
        for (int t = 0; t < 3; t++) begin
            in_a = 16'h1111 * 16'(t + 1); in_b = 16'h0F0F; in_cin = 1'b0; in_sub = 1'b0;
            in_tag = 4'(t + 1); in_valid = 1'b1;
            cycle();
        end
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_outputs", obs_main(), '0);
        sb.delete(); hold_vld = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int t = 0; t < 6; t++) begin
            check("no_stale_result", out_valid, 1'b0);
            cycle();
        end

        // Backpressure: tags 0..7, with downstream stalled for 5 cycles mid-stream.
        sb.delete(); pops = 0; saw_block = 1'b0; hold_vld = 1'b0;
        cyc = 0; stall_lo = 5; stall_hi = 10;
        for (int t = 0; t < 8; t++) begin
            in_a = 16'($urandom); in_b = 16'($urandom);
            in_cin = 1'($urandom); in_sub = 1'($urandom);
            in_tag = 4'(t); in_valid = 1'b1;
            tries = 0;
            do begin
                cycle();
                tries++;
            end while (!accepted && tries < 50);
        end
        in_valid = 1'b0;
        tries = 0;
        while (sb.size() > 0 && tries < 50) begin
            cycle();
            tries++;
        end
        check("bp_results_out", pops, 8);
        check("bp_in_ready_fell", saw_block, 1'b1);
        check("bp_scoreboard_empty", sb.size(), 0);

        // Throughput: 100 back-to-back operations with no downstream stall.
        stall_lo = 0; stall_hi = 0; pops = 0; nstall = 0;
        for (int t = 0; t < 100; t++) begin
            in_a = 16'($urandom); in_b = 16'($urandom);
            in_cin = 1'($urandom); in_sub = 1'($urandom);
            in_tag = 4'(t); in_valid = 1'b1;
            cycle();
            if (!accepted) nstall++;
        end
        in_valid = 1'b0;
        repeat (3) cycle();
        check("tp_no_input_stall", nstall, 0);
        check("tp_one_per_cycle", pops, 100);
        check("tp_scoreboard_empty", sb.size(), 0);

        // Parameter corners.
        param_op(13, 64'h1FFF, 64'h0001, 1'b0, 1'b0, 4'h1, 5);
        param_op(13, 64'h0FFF, 64'h0001, 1'b0, 1'b0, 4'h2, 5);
        param_op(13, 64'h1000, 64'h0001, 1'b0, 1'b1, 4'h3, 5);
        param_op(64, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 4'h4, 3);
        param_op(64, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 4'h5, 3);
        param_op(64, 64'h0000_0000_0000_0005, 64'h7, 1'b0, 1'b1, 4'h6, 3);
        for (int t = 0; t < 6; t++) begin
            param_op(13, {32'd0, $urandom}, {32'd0, $urandom}, 1'($urandom), 1'($urandom), 4'(t), 5);
            param_op(64, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom), 4'(t), 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
